// File: rtl/multi_cycle_control_if.sv
// Control-to-datapath bundle of the multi-cycle MIPS control unit.
// The master side is the control unit; the slave side is the datapath/memory.
interface multi_cycle_control_if #(
    parameter int CNT_W = 16
);
    logic [5:0]       op;
    logic [5:0]       funct;
    logic             mem_ready;
    logic             alu_zero;
    logic             pc_wen;
    logic             ir_wen;
    logic             iord;
    logic             mem_ren;
    logic             mem_wen;
    logic             rf_wen;
    logic             rf_dst;
    logic             data_rf;
    logic             alu_src_a;
    logic [1:0]       alu_src_b;
    logic [3:0]       alu_ct;
    logic [1:0]       pc_src;
    logic [2:0]       state;
    logic             illegal;
    logic             mem_err;
    logic [CNT_W-1:0] inst_count;

    modport master (
        input  op, funct, mem_ready, alu_zero,
        output pc_wen, ir_wen, iord, mem_ren, mem_wen, rf_wen, rf_dst, data_rf,
               alu_src_a, alu_src_b, alu_ct, pc_src, state, illegal, mem_err, inst_count
    );

    modport slave (
        output op, funct, mem_ready, alu_zero,
        input  pc_wen, ir_wen, iord, mem_ren, mem_wen, rf_wen, rf_dst, data_rf,
               alu_src_a, alu_src_b, alu_ct, pc_src, state, illegal, mem_err, inst_count
    );
endinterface

// File: rtl/multi_cycle_control.sv
// Multi-cycle MIPS control FSM: fetch/decode/exec/mem/writeback sequencing,
// memory handshake with a wait watchdog, sticky fault flags and a retire counter.
module multi_cycle_control #(
    parameter int WAIT_LIMIT  = 15,
    parameter bit ENABLE_BNE  = 1'b1,
    parameter bit ENABLE_SLTI = 1'b1,
    parameter int CNT_W       = 16
) (
    input logic clk,
    input logic rst,
    multi_cycle_control_if.master bus
);
    localparam logic [2:0] S_FETCH  = 3'd0;
    localparam logic [2:0] S_DECODE = 3'd1;
    localparam logic [2:0] S_EXEC   = 3'd2;
    localparam logic [2:0] S_MEM    = 3'd3;
    localparam logic [2:0] S_WB     = 3'd4;
    localparam logic [2:0] S_BRANCH = 3'd5;
    localparam logic [2:0] S_JUMP   = 3'd6;
    localparam logic [2:0] S_HALT   = 3'd7;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [5:0] FN_ADDU = 6'b100001;
    localparam logic [5:0] FN_SUBU = 6'b100011;
    localparam logic [5:0] FN_AND  = 6'b100100;
    localparam logic [5:0] FN_OR   = 6'b100101;
    localparam logic [5:0] FN_SLT  = 6'b101010;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;

    // The counter only ever needs to hold WAIT_LIMIT-1 before the watchdog fires.
    localparam int               WAIT_W    = (WAIT_LIMIT < 2) ? 1 : $clog2(WAIT_LIMIT);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(WAIT_LIMIT - 1);

    logic [2:0]        state_r;
    logic [2:0]        state_nx_s;
    logic [5:0]        op_r;
    logic [5:0]        funct_r;
    logic              illegal_r;
    logic              mem_err_r;
    logic [CNT_W-1:0]  cnt_r;
    logic [WAIT_W-1:0] wait_cnt_r;
    logic              mem_wait_s;
    logic              wd_fire_s;
    logic              retire_s;
    logic              dec_legal_s;

    logic       pc_wen_s, ir_wen_s, iord_s, mem_ren_s, mem_wen_s;
    logic       rf_wen_s, rf_dst_s, data_rf_s, alu_src_a_s;
    logic [1:0] alu_src_b_s, pc_src_s;
    logic [3:0] alu_ct_s;

    function automatic logic funct_legal(input logic [5:0] f);
        case (f)
            FN_ADDU, FN_SUBU, FN_AND, FN_OR, FN_SLT: funct_legal = 1'b1;
            default:                                 funct_legal = 1'b0;
        endcase
    endfunction

    function automatic logic op_legal(input logic [5:0] o, input logic [5:0] f);
        case (o)
            OP_RTYPE:                              op_legal = funct_legal(f);
            OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDIU:  op_legal = 1'b1;
            OP_BNE:                                op_legal = ENABLE_BNE;
            OP_SLTI:                               op_legal = ENABLE_SLTI;
            default:                               op_legal = 1'b0;
        endcase
    endfunction

    function automatic logic [3:0] funct_alu(input logic [5:0] f);
        case (f)
            FN_ADDU: funct_alu = ALU_ADD;
            FN_SUBU: funct_alu = ALU_SUB;
            FN_AND:  funct_alu = ALU_AND;
            FN_OR:   funct_alu = ALU_OR;
            FN_SLT:  funct_alu = ALU_SLT;
            default: funct_alu = ALU_ADD;
        endcase
    endfunction

    assign dec_legal_s = op_legal(bus.op, bus.funct);
    assign mem_wait_s  = ((state_r == S_FETCH) || (state_r == S_MEM)) && !bus.mem_ready;
    assign wd_fire_s   = (WAIT_LIMIT != 0) && mem_wait_s && (wait_cnt_r == WAIT_LAST);
    assign retire_s    = (state_nx_s == S_FETCH) && (state_r != S_FETCH);

    // Next-state selection.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            S_FETCH: begin
                if (bus.mem_ready)   state_nx_s = S_DECODE;
                else if (wd_fire_s)  state_nx_s = S_HALT;
                else                 state_nx_s = S_FETCH;
            end
            S_DECODE: begin
                if (!dec_legal_s) begin
                    state_nx_s = S_HALT;
                end else begin
                    case (bus.op)
                        OP_BEQ, OP_BNE: state_nx_s = S_BRANCH;
                        OP_J:           state_nx_s = S_JUMP;
                        default:        state_nx_s = S_EXEC;
                    endcase
                end
            end
            S_EXEC: begin
                if ((op_r == OP_LW) || (op_r == OP_SW)) state_nx_s = S_MEM;
                else                                    state_nx_s = S_WB;
            end
            S_MEM: begin
                if (bus.mem_ready)   state_nx_s = (op_r == OP_SW) ? S_FETCH : S_WB;
                else if (wd_fire_s)  state_nx_s = S_HALT;
                else                 state_nx_s = S_MEM;
            end
            S_WB, S_BRANCH, S_JUMP: state_nx_s = S_FETCH;
            S_HALT:                 state_nx_s = S_HALT;
            default:                state_nx_s = S_HALT;
        endcase
    end

    // State register and the instruction fields captured in DECODE.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= S_FETCH;
            op_r    <= 6'd0;
            funct_r <= 6'd0;
        end else begin
            state_r <= state_nx_s;
            if (state_r == S_DECODE) begin
                op_r    <= bus.op;
                funct_r <= bus.funct;
            end
        end
    end

    // Sticky fault flags and the retired-instruction counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            illegal_r <= 1'b0;
            mem_err_r <= 1'b0;
            cnt_r     <= '0;
        end else begin
            if ((state_r == S_DECODE) && !dec_legal_s) illegal_r <= 1'b1;
            if (wd_fire_s)                              mem_err_r <= 1'b1;
            if (retire_s)                               cnt_r     <= cnt_r + CNT_W'(1);
        end
    end

    // Memory wait counter: restarts whenever the FSM enters a new state.
    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt_r <= '0;
        end else if (state_nx_s != state_r) begin
            wait_cnt_r <= '0;
        end else if (mem_wait_s) begin
            wait_cnt_r <= wait_cnt_r + WAIT_W'(1);
        end
    end

    // Datapath strobes and mux selects per state.
    always_comb begin
        pc_wen_s    = 1'b0;
        ir_wen_s    = 1'b0;
        iord_s      = 1'b0;
        mem_ren_s   = 1'b0;
        mem_wen_s   = 1'b0;
        rf_wen_s    = 1'b0;
        rf_dst_s    = 1'b0;
        data_rf_s   = 1'b0;
        alu_src_a_s = 1'b0;
        alu_src_b_s = 2'b00;
        alu_ct_s    = ALU_AND;
        pc_src_s    = 2'b00;
        case (state_r)
            S_FETCH: begin
                mem_ren_s   = 1'b1;
                alu_src_b_s = 2'b01;
                alu_ct_s    = ALU_ADD;
                ir_wen_s    = bus.mem_ready;
                pc_wen_s    = bus.mem_ready;
            end
            S_DECODE: begin
                alu_src_b_s = 2'b11;
                alu_ct_s    = ALU_ADD;
            end
            S_EXEC: begin
                alu_src_a_s = 1'b1;
                case (op_r)
                    OP_RTYPE: begin
                        alu_src_b_s = 2'b00;
                        alu_ct_s    = funct_alu(funct_r);
                    end
                    OP_SLTI: begin
                        alu_src_b_s = 2'b10;
                        alu_ct_s    = ALU_SLT;
                    end
                    default: begin
                        alu_src_b_s = 2'b10;
                        alu_ct_s    = ALU_ADD;
                    end
                endcase
            end
            S_MEM: begin
                iord_s    = 1'b1;
                mem_ren_s = (op_r == OP_LW);
                mem_wen_s = (op_r == OP_SW);
            end
            S_WB: begin
                rf_wen_s  = 1'b1;
                rf_dst_s  = (op_r == OP_RTYPE);
                data_rf_s = (op_r == OP_LW);
            end
            S_BRANCH: begin
                alu_src_a_s = 1'b1;
                alu_src_b_s = 2'b00;
                alu_ct_s    = ALU_SUB;
                pc_src_s    = 2'b01;
                pc_wen_s    = (op_r == OP_BNE) ? !bus.alu_zero : bus.alu_zero;
            end
            S_JUMP: begin
                pc_src_s = 2'b10;
                pc_wen_s = 1'b1;
            end
            default: begin
                pc_wen_s = 1'b0;
            end
        endcase
    end

    // Strobes are masked while reset is asserted so nothing writes mid-reset.
    assign bus.pc_wen     = pc_wen_s  & ~rst;
    assign bus.ir_wen     = ir_wen_s  & ~rst;
    assign bus.mem_ren    = mem_ren_s & ~rst;
    assign bus.mem_wen    = mem_wen_s & ~rst;
    assign bus.rf_wen     = rf_wen_s  & ~rst;
    assign bus.iord       = iord_s;
    assign bus.rf_dst     = rf_dst_s;
    assign bus.data_rf    = data_rf_s;
    assign bus.alu_src_a  = alu_src_a_s;
    assign bus.alu_src_b  = alu_src_b_s;
    assign bus.alu_ct     = alu_ct_s;
    assign bus.pc_src     = pc_src_s;
    assign bus.state      = state_r;
    assign bus.illegal    = illegal_r;
    assign bus.mem_err    = mem_err_r;
    assign bus.inst_count = cnt_r;
endmodule
